// File: rtl/hwlp_gen_if.sv
// Handshake, configuration and status bundle of the nested hardware loop generator.
// The producer of tuples (the loop unit) uses the slave modport; the controller/consumer side uses master.
interface hwlp_gen_if #(
  parameter int N_LP     = 4,
  parameter int NBIT_IV  = 16,
  parameter int NBIT_II  = 4,
  parameter int NBIT_NLP = $clog2(N_LP + 1)
);
  logic                      start_i;
  logic                      abort_i;
  logic [NBIT_II-1:0]        cfg_ii_i;
  logic [NBIT_NLP-1:0]       cfg_n_lp_i;
  logic [N_LP*NBIT_IV-1:0]   cfg_iv_i;
  logic [N_LP*NBIT_IV-1:0]   cfg_fv_i;
  logic [N_LP*NBIT_IV-1:0]   cfg_inc_i;
  logic                      ready_i;
  logic [N_LP*NBIT_IV-1:0]   loop_vars_o;
  logic [N_LP-1:0]           end_cond_o;
  logic                      valid_o;
  logic                      last_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    output start_i, abort_i, cfg_ii_i, cfg_n_lp_i, cfg_iv_i, cfg_fv_i, cfg_inc_i, ready_i,
    input  loop_vars_o, end_cond_o, valid_o, last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, cfg_ii_i, cfg_n_lp_i, cfg_iv_i, cfg_fv_i, cfg_inc_i, ready_i,
    output loop_vars_o, end_cond_o, valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/hwlp_gen.sv
// N-level nested hardware loop unit: emits induction-variable tuples every II cycles with
// valid/ready backpressure, runtime depth selection, signed increments, abort and done status.
//
// state | meaning
// IDLE  | waiting for start with a legal active-level count
// RUN   | emitting tuples; a tuple is offered when ii_cnt == 0
// DONE  | one-cycle completion pulse, vars back at latched iv
module hwlp_gen #(
  parameter int N_LP     = 4,
  parameter int NBIT_IV  = 16,
  parameter int NBIT_II  = 4,
  parameter int NBIT_NLP = $clog2(N_LP + 1)
) (
  input logic       clk_i,
  input logic       rst_n_i,
  hwlp_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [NBIT_NLP-1:0] NLP_MAX = NBIT_NLP'(N_LP);

  state_t               state, state_nxt;
  logic [NBIT_II-1:0]   ii_cnt, ii_q;
  logic [NBIT_NLP-1:0]  nlp_q;
  logic [NBIT_IV-1:0]   var_q [N_LP];
  logic [NBIT_IV-1:0]   iv_q  [N_LP];
  logic [NBIT_IV-1:0]   fv_q  [N_LP];
  logic [NBIT_IV-1:0]   inc_q [N_LP];
  logic [N_LP-1:0]      ec, step;
  logic                 cfg_ok, valid, last;
  logic                 load, finish, advance, clr_cnt, wrap;

  assign cfg_ok = (bus.cfg_n_lp_i != '0) && (bus.cfg_n_lp_i <= NLP_MAX);
  assign valid  = (state == RUN) && (ii_cnt == '0);

  // Inactive levels report "ended" so the carry chain passes straight through them.
  always_comb begin
    ec = '0;
    for (int i = 0; i < N_LP; i++) begin
      ec[i] = (NBIT_NLP'(i) >= nlp_q) || (var_q[i] == fv_q[i]);
    end
  end

  always_comb begin
    step    = '0;
    step[0] = 1'b1;
    for (int i = 1; i < N_LP; i++) begin
      step[i] = step[i-1] & ec[i-1];
    end
  end

  assign last = valid && (&ec);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    advance   = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i && cfg_ok && !bus.abort_i) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_nxt = IDLE;
          clr_cnt   = 1'b1;
        end else if (valid && bus.ready_i && last) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end else if (!(valid && !bus.ready_i)) begin
          advance = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wrap = advance && (ii_cnt == ii_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ii_cnt <= '0;
      ii_q   <= '0;
      nlp_q  <= '0;
      for (int i = 0; i < N_LP; i++) begin
        var_q[i] <= '0;
        iv_q[i]  <= '0;
        fv_q[i]  <= '0;
        inc_q[i] <= '0;
      end
    end else if (load) begin
      ii_cnt <= '0;
      ii_q   <= bus.cfg_ii_i;
      nlp_q  <= bus.cfg_n_lp_i;
      for (int i = 0; i < N_LP; i++) begin
        var_q[i] <= bus.cfg_iv_i[i*NBIT_IV +: NBIT_IV];
        iv_q[i]  <= bus.cfg_iv_i[i*NBIT_IV +: NBIT_IV];
        fv_q[i]  <= bus.cfg_fv_i[i*NBIT_IV +: NBIT_IV];
        inc_q[i] <= bus.cfg_inc_i[i*NBIT_IV +: NBIT_IV];
      end
    end else if (finish) begin
      ii_cnt <= '0;
      for (int i = 0; i < N_LP; i++) begin
        var_q[i] <= iv_q[i];
      end
    end else if (clr_cnt) begin
      ii_cnt <= '0;
    end else if (advance) begin
      ii_cnt <= wrap ? '0 : ii_cnt + 1'b1;
      if (wrap) begin
        for (int i = 0; i < N_LP; i++) begin
          if (step[i]) var_q[i] <= ec[i] ? iv_q[i] : var_q[i] + inc_q[i];
        end
      end
    end
  end

  always_comb begin
    bus.loop_vars_o = '0;
    for (int i = 0; i < N_LP; i++) begin
      bus.loop_vars_o[i*NBIT_IV +: NBIT_IV] = var_q[i];
    end
  end

  assign bus.end_cond_o = (state == RUN) ? ec : '0;
  assign bus.valid_o    = valid;
  assign bus.last_o     = last;
  assign bus.busy_o     = (state != IDLE);
  assign bus.done_o     = (state == DONE);

endmodule

// File: tb/tb_hwlp_gen.sv
// Scoreboard bench for hwlp_gen: a mixed-radix reference model predicts every tuple at start,
// a negedge monitor pops and compares on each accepted tuple and checks II spacing and done.
module tb_hwlp_gen;
  localparam int N_LP     = 4;
  localparam int NBIT_IV  = 16;
  localparam int NBIT_II  = 4;
  localparam int NBIT_NLP = 3;
  localparam int BOUND    = 6000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hwlp_gen_if #(.N_LP(N_LP), .NBIT_IV(NBIT_IV), .NBIT_II(NBIT_II), .NBIT_NLP(NBIT_NLP)) bus ();

  hwlp_gen #(.N_LP(N_LP), .NBIT_IV(NBIT_IV), .NBIT_II(NBIT_II), .NBIT_NLP(NBIT_NLP)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [N_LP*NBIT_IV-1:0] vars;
    logic [N_LP-1:0]         ec;
    logic                    last;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   failures = 0;
  int   acc_total = 0;
  int   cyc = 0;
  int   prev_cyc = 0;
  int   stalls = 0;
  int   exp_ii = 0;
  bit   have_prev = 0;
  bit   stalled = 0;
  bit   exp_done = 0;
  bit   acc = 0;
  logic [N_LP*NBIT_IV-1:0] held;

  logic [NBIT_IV-1:0] c_iv  [N_LP];
  logic [NBIT_IV-1:0] c_fv  [N_LP];
  logic [NBIT_IV-1:0] c_inc [N_LP];
  int c_nlp;
  int c_ii;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Tuple k is the mixed-radix number k over the active level trip counts, level 0 least significant.
  task automatic push_expected();
    int n [N_LP];
    int total;
    int rem;
    int d;
    logic [NBIT_IV-1:0] v;
    exp_t e;
    total = 1;
    for (int i = 0; i < N_LP; i++) begin
      n[i] = 1;
      if (i < c_nlp) begin
        v = c_iv[i];
        while (v != c_fv[i] && n[i] < 300) begin
          v = v + c_inc[i];
          n[i]++;
        end
        total = total * n[i];
      end
    end
    for (int k = 0; k < total; k++) begin
      rem = k;
      for (int i = 0; i < N_LP; i++) begin
        d = rem % n[i];
        rem = rem / n[i];
        v = c_iv[i] + NBIT_IV'(d) * c_inc[i];
        e.vars[i*NBIT_IV +: NBIT_IV] = v;
        e.ec[i] = (i >= c_nlp) || (d == n[i] - 1);
      end
      e.last = (k == total - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_cfg();
    bus.cfg_ii_i   = NBIT_II'(c_ii);
    bus.cfg_n_lp_i = NBIT_NLP'(c_nlp);
    for (int i = 0; i < N_LP; i++) begin
      bus.cfg_iv_i[i*NBIT_IV +: NBIT_IV]  = c_iv[i];
      bus.cfg_fv_i[i*NBIT_IV +: NBIT_IV]  = c_fv[i];
      bus.cfg_inc_i[i*NBIT_IV +: NBIT_IV] = c_inc[i];
    end
  endtask

  task automatic set_cfg1();
    c_nlp = 2;
    c_ii  = 0;
    for (int i = 0; i < N_LP; i++) begin
      c_iv[i] = '0; c_fv[i] = '0; c_inc[i] = '0;
    end
    c_fv[0] = 16'd2; c_inc[0] = 16'd1;
    c_fv[1] = 16'd1; c_inc[1] = 16'd1;
  endtask

  task automatic run(input int ready_pct, input int abort_at, input bit poke,
                     input int stall_at, input int stall_len);
    int  base;
    int  stall_left;
    int  cycles;
    bit  aborted;
    stall_left = stall_len;
    cycles = 0;
    aborted = 0;
    @(posedge clk); #1;
    drive_cfg();
    bus.start_i = 1'b1;
    exp_ii = c_ii;
    push_expected();
    base = acc_total;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    chk("first_valid", bus.valid_o, 1);
    chk("busy_after_start", bus.busy_o, 1);
    while (bus.busy_o) begin
      bus.ready_i = ($urandom_range(99) < ready_pct);
      if (bus.valid_o && (acc_total - base) == stall_at && stall_left > 0) begin
        bus.ready_i = 1'b0;
        stall_left--;
      end
      if (poke) begin
        bus.start_i    = 1'($urandom_range(1));
        bus.cfg_ii_i   = NBIT_II'($urandom);
        bus.cfg_n_lp_i = NBIT_NLP'($urandom_range(1, 4));
        bus.cfg_iv_i   = {$urandom, $urandom};
        bus.cfg_fv_i   = {$urandom, $urandom};
        bus.cfg_inc_i  = {$urandom, $urandom};
      end
      if (abort_at >= 0 && bus.valid_o && (acc_total - base) == abort_at) begin
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        chk("abort_valid", bus.valid_o, 0);
        chk("abort_busy", bus.busy_o, 0);
        sb.delete();
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      cycles++;
      if (cycles > BOUND) begin
        checks++;
        failures++;
        $display("FAIL run_timeout actual=busy required=idle within %0d cycles", BOUND);
        sb.delete();
        break;
      end
    end
    bus.start_i = 1'b0;
    bus.ready_i = 1'b0;
    if (!aborted) chk("sb_drained", sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, bus.valid_o, 0);
    chk({tag, "_last"}, bus.last_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_vars"}, bus.loop_vars_o, 0);
    chk({tag, "_ec"}, bus.end_cond_o, 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_done  = 0;
      stalled   = 0;
      have_prev = 0;
      stalls    = 0;
    end else begin
      if (exp_done || bus.done_o) begin
        chk("done_pulse", bus.done_o, exp_done);
        if (bus.done_o) chk("busy_at_done", bus.busy_o, 1);
      end
      if (stalled) begin
        chk("stall_valid_hold", bus.valid_o, 1);
        chk("stall_vars_hold", bus.loop_vars_o, held);
      end
      acc      = bus.valid_o && bus.ready_i && !bus.abort_i;
      exp_done = acc && bus.last_o;
      stalled  = bus.valid_o && !bus.ready_i && !bus.abort_i;
      if (stalled) begin
        held = bus.loop_vars_o;
        stalls++;
      end
      if (acc) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_tuple actual=%0h required=no_tuple", bus.loop_vars_o);
        end else begin
          got = sb.pop_front();
          chk("tuple_vars", bus.loop_vars_o, got.vars);
          chk("tuple_ec", bus.end_cond_o, got.ec);
          chk("tuple_last", bus.last_o, got.last);
        end
        if (have_prev) chk("ii_gap", cyc - prev_cyc, exp_ii + 1 + stalls);
        prev_cyc  = cyc;
        have_prev = 1;
        stalls    = 0;
        acc_total++;
      end
      if (!bus.busy_o) begin
        have_prev = 0;
        stalls    = 0;
      end
    end
  end

  initial begin
    int n;
    int inc;
    bus.start_i    = 1'b0;
    bus.abort_i    = 1'b0;
    bus.ready_i    = 1'b0;
    bus.cfg_ii_i   = '0;
    bus.cfg_n_lp_i = '0;
    bus.cfg_iv_i   = '0;
    bus.cfg_fv_i   = '0;
    bus.cfg_inc_i  = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 2x3 nest, one tuple per cycle
    set_cfg1();
    run(100, -1, 0, -1, 0);
    // same nest at II = 3
    c_ii = 2;
    run(100, -1, 0, -1, 0);
    // three-cycle stall on tuple (1,0)
    c_ii = 0;
    run(100, -1, 0, 1, 3);

    // single active level, negative increment; upper levels parked at iv
    c_nlp = 1; c_ii = 0;
    c_iv[0] = 16'd10; c_fv[0] = 16'd4; c_inc[0] = 16'hFFFD;
    c_iv[1] = 16'd5;  c_iv[2] = 16'd6; c_iv[3] = 16'd7;
    c_fv[1] = 16'd99; c_fv[2] = 16'd1; c_fv[3] = 16'd7;
    c_inc[1] = 16'd1; c_inc[2] = 16'd2; c_inc[3] = 16'd3;
    run(100, -1, 0, -1, 0);

    // illegal active-level counts leave the unit idle
    foreach (c_iv[i]) c_iv[i] = '0;
    c_nlp = 0;
    @(posedge clk); #1;
    drive_cfg(); bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    chk("nlp0_busy", bus.busy_o, 0);
    chk("nlp0_valid", bus.valid_o, 0);
    c_nlp = 5;
    drive_cfg(); bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    chk("nlp5_busy", bus.busy_o, 0);

    // abort on the third tuple, then a fresh run
    set_cfg1();
    run(100, 2, 0, -1, 0);
    run(100, -1, 0, -1, 0);

    // asynchronous reset mid-run
    @(posedge clk); #1;
    drive_cfg(); bus.start_i = 1'b1;
    exp_ii = c_ii;
    push_expected();
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ready_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", bus.busy_o, 0);

    // full 4-level binary count at II = 2 with config and start churn mid-run
    c_nlp = 4; c_ii = 1;
    for (int i = 0; i < N_LP; i++) begin
      c_iv[i] = '0; c_fv[i] = 16'd1; c_inc[i] = 16'd1;
    end
    run(100, -1, 1, -1, 0);

    // randomized nests with random backpressure
    for (int r = 0; r < 10; r++) begin
      c_nlp = $urandom_range(1, 4);
      c_ii  = $urandom_range(0, 3);
      for (int i = 0; i < N_LP; i++) begin
        n   = $urandom_range(1, 3);
        inc = $urandom_range(1, 4);
        if ($urandom_range(1) == 1) inc = -inc;
        c_iv[i]  = NBIT_IV'($urandom);
        c_inc[i] = NBIT_IV'(inc);
        c_fv[i]  = c_iv[i] + NBIT_IV'(n - 1) * c_inc[i];
      end
      run(70, (r == 9) ? 3 : -1, (r % 3) == 0, -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
